// File: rtl/srff_arb_pkg.sv
// Shared types and widths for the round-robin SR-flag arbiter.
// Optional feature elsewhere: SRFF_ARB_CONFLICT_CNT_EN adds a contention counter.
package srff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int HOLD_CNT_W     = 4;
  localparam int CONFLICT_CNT_W = 8;

  // Number of set bits in a request vector of up to 8 requesters.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/srff_arbiter_cell.sv
// Shared SR flag flop: 10 sets, 01 clears, 00 holds; the arbiter never drives 11.
module srff_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({s, r})
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/srff_arbiter.sv
// Round-robin arbiter serialising set/clear requests onto one shared SR flag.
// Define SRFF_ARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module srff_arbiter
  import srff_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  output logic [N_REQ-1:0] grant,
  output logic             s_out,
  output logic             r_out,
  output logic             q,
  output logic             busy,
  output logic             illegal
`ifdef SRFF_ARB_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_CNT_W'(HOLD_CYCLES - 1) : '0;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic                    s_q, s_d;
  logic                    r_q, r_d;
  logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    illegal_q, illegal_d;

  logic [N_REQ-1:0]        valid;
  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic                    arb_en;

  // A requester asserting both set and clear is simply not a candidate.
  assign valid     = set_req ^ clr_req;
  assign illegal_d = |(set_req & clr_req);

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr_q) + off) % N_REQ;
      if (!win_found && valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Arbitration happens in IDLE and also on the final busy edge, so that
  // a held request is re-granted exactly 1+HOLD_CYCLES cycles after the last.
  always_comb begin
    arb_en = 1'b1;
    case (state_q)
      IDLE:    arb_en = 1'b1;
      DRIVE:   arb_en = (HOLD_CYCLES == 0);
      HOLD:    arb_en = (cnt_q == '0);
      default: arb_en = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    s_d     = 1'b0;
    r_d     = 1'b0;
    cnt_d   = cnt_q;
    if (arb_en) begin
      state_d = IDLE;
      if (win_found) begin
        state_d          = DRIVE;
        grant_d[win_idx] = 1'b1;
        s_d              = set_req[win_idx];
        r_d              = clr_req[win_idx];
        ptr_d            = PTR_W'((int'(win_idx) + 1) % N_REQ);
      end
    end else if (state_q == DRIVE) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      s_q       <= s_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef SRFF_ARB_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Contention is counted once per arbitration decision, saturating at all-ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (arb_en && (popcount8(8'(valid)) >= 4'd2) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  srff_cell u_cell (
    .clk (clk),
    .rst (rst),
    .s   (s_q),
    .r   (r_q),
    .q   (q)
  );

  assign grant   = grant_q;
  assign s_out   = s_q;
  assign r_out   = r_q;
  assign busy    = (state_q != IDLE);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_srff_arbiter.sv
// Self-checking bench for srff_arbiter (N_REQ=4, HOLD_CYCLES=2): vector table plus corner sequences.
module tb_srff_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] set_req;
  logic [3:0] clr_req;
  logic [3:0] grant;
  logic       s_out;
  logic       r_out;
  logic       q;
  logic       busy;
  logic       illegal;
`ifdef SRFF_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  srff_arbiter #(.N_REQ(4), .HOLD_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .grant   (grant),
    .s_out   (s_out),
    .r_out   (r_out),
    .q       (q),
    .busy    (busy),
    .illegal (illegal)
`ifdef SRFF_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] set;
    logic [3:0] clr;
    logic [3:0] g;
    logic       s;
    logic       r;
    logic       q;
    logic       busy;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic r_, input logic [3:0] st, input logic [3:0] cl,
                              input logic [3:0] g_, input logic s_, input logic rr,
                              input logic q_, input logic b_, input logic i_);
    vec_t v;
    v.rst = r_; v.set = st; v.clr = cl; v.g = g_; v.s = s_; v.r = rr;
    v.q = q_; v.busy = b_; v.ill = i_;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;
    logic found;
    int   n;
    int   grants;

    // Each entry: inputs before the edge, expected outputs just after it.
    //   rst set      clr      grant    s     r     q     busy  illegal
    add(1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reset
    add(1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // single set
    add(0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // re-grant at +3
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reset before RR
    add(0, 4'b0101, 4'b1010, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // round robin
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(0, 4'b0101, 4'b1010, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // wraps to 0
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); // illegal
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // set while q=1
    add(1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reset in DRIVE
    add(0, 4'b1001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // ptr back at 0
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    rst = 1'b1; set_req = '0; clr_req = '0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; set_req = v.set; clr_req = v.clr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("grant",   i, 32'(grant),   32'(e.g));
      chk("s_out",   i, 32'(s_out),   32'(e.s));
      chk("r_out",   i, 32'(r_out),   32'(e.r));
      chk("q",       i, 32'(q),       32'(e.q));
      chk("busy",    i, 32'(busy),    32'(e.busy));
      chk("illegal", i, 32'(illegal), 32'(e.ill));
      chk("s_and_r", i, 32'(s_out & r_out), 32'(0));
    end

    // Pointer sits at 1: a lone set from requester 1 is served next, q already 1.
    set_req = 4'b0010; clr_req = '0; found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (grant != '0) begin found = 1'b1; break; end
    end
    chk("seq_grant_seen", 100, 32'(found), 32'(1));
    chk("seq_grant",      101, 32'(grant), 32'(4'b0010));
    chk("seq_s_out",      102, 32'(s_out), 32'(1));
    set_req = '0;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("seq_busy_len", 103, 32'(n), 32'(3));
    chk("seq_q_kept",   104, 32'(q), 32'(1));

`ifdef SRFF_ARB_CONFLICT_CNT_EN
    rst = 1'b1; @(posedge clk); #1;
    chk("cc_reset", 200, 32'(conflict_cnt), 32'(0));
    rst = 1'b0;
    set_req = 4'b0111; clr_req = '0; grants = 0; n = 0;
    while (grants < 2 && n < 20) begin
      @(posedge clk); #1; n++;
      if (grant != '0) grants++;
    end
    chk("cc_two_rounds_seen", 201, 32'(grants), 32'(2));
    chk("cc_two_rounds",      202, 32'(conflict_cnt), 32'(2));
    for (int i = 0; i < 900; i++) begin
      @(posedge clk);
    end
    #1;
    chk("cc_saturate", 203, 32'(conflict_cnt), 32'(255));
    set_req = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
